// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit and sequencer for the E stage.
// Owns the architectural HI/LO registers. The result of mult/multu/div/divu is
// computed when the op is issued and parked in temp registers. A busy counter
// then models the fixed latency before the result is committed to HI/LO.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   E_MDop    op in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   E_valid   E instruction is real (not a bubble or flushed)
//   E_A/E_B   forwarded GRF[rs]/GRF[rt]
//   D_md_use  instruction in D is an MDU op
//   busy      multiply/divide in progress
//   md_stall  stall request for F/D
//   E_MDout   HI for mfhi, LO for mflo, else 0
//   HI/LO     architectural HI/LO
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDop,
    input  logic        E_valid,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] E_MDout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] tmp_hi_q, tmp_lo_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;
    logic        dz_q;      // pending op was a divide by zero: skip the commit

    logic        start;
    logic        is_div;
    logic        div_zero;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b_nz, a_mag, b_mag;
    logic [31:0] dv_a, dv_b, dv_q, dv_r;
    logic [31:0] tmp_hi_d, tmp_lo_d;

    assign start    = E_valid && (E_MDop >= OP_MULT) && (E_MDop <= OP_DIVU);
    assign is_div   = (E_MDop == OP_DIV) || (E_MDop == OP_DIVU);
    assign div_zero = (E_B == 32'd0);

    // Sign/zero extend to 64 bits; the truncated 64-bit product is exact.
    assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    // One unsigned divider serves both div and divu. Signed division runs on
    // magnitudes and fixes signs afterwards, so 0x80000000 / -1 falls out as
    // 0x80000000 rem 0 without a special case. A zero divisor is replaced by 1
    // so the datapath never produces X; the result is discarded anyway.
    assign div_b_nz = div_zero ? 32'd1 : E_B;
    assign a_mag    = E_A[31] ? (32'd0 - E_A) : E_A;
    assign b_mag    = div_b_nz[31] ? (32'd0 - div_b_nz) : div_b_nz;
    assign dv_a     = (E_MDop == OP_DIV) ? a_mag : E_A;
    assign dv_b     = (E_MDop == OP_DIV) ? b_mag : div_b_nz;
    assign dv_q     = dv_a / dv_b;
    assign dv_r     = dv_a % dv_b;

    always_comb begin
        tmp_hi_d = 32'd0;
        tmp_lo_d = 32'd0;
        case (E_MDop)
            OP_MULT:  {tmp_hi_d, tmp_lo_d} = prod_s;
            OP_MULTU: {tmp_hi_d, tmp_lo_d} = prod_u;
            OP_DIV: begin
                tmp_lo_d = (E_A[31] ^ div_b_nz[31]) ? (32'd0 - dv_q) : dv_q;
                tmp_hi_d = E_A[31] ? (32'd0 - dv_r) : dv_r;
            end
            OP_DIVU: begin
                tmp_lo_d = dv_q;
                tmp_hi_d = dv_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tmp_hi_q <= tmp_hi_d;
                        tmp_lo_q <= tmp_lo_d;
                        dz_q     <= is_div && div_zero;
                        cnt_q    <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        busy_q   <= 1'b1;
                        state_q  <= BUSY;
                    end else if (E_valid && E_MDop == OP_MTHI) begin
                        hi_q <= E_A;
                    end else if (E_valid && E_MDop == OP_MTLO) begin
                        lo_q <= E_A;
                    end
                end
                BUSY: begin
                    // Starts and mthi/mtlo here are illegal (stalled in D) and ignored.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (!dz_q) begin
                            hi_q <= tmp_hi_q;
                            lo_q <= tmp_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall also covers the issue cycle, before busy has risen.
    assign md_stall = D_md_use && (busy_q || start);
    assign busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

    always_comb begin
        E_MDout = 32'd0;
        if (E_MDop == OP_MFHI)      E_MDout = hi_q;
        else if (E_MDop == OP_MFLO) E_MDout = lo_q;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and its sequencer, sitting in the Execute stage next to the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo issued from E and owns the HI/LO registers.
- Models the fixed mult/div latency with a busy counter.
- Produces the stall request that holds any MDU-using instruction in Decode while an operation is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- E_MDop  input  4  op in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
- E_valid  input  1  E instruction is real (not a bubble or flushed)
- E_A  input  32  forwarded GRF[rs] in E
- E_B  input  32  forwarded GRF[rt] in E
- D_md_use  input  1  instruction in D is any MDU op (codes 1-8)
- busy  output  1  operation in progress
- md_stall  output  1  stall request to the hazard unit for F/D
- E_MDout  output  32  HI for mfhi, LO for mflo, else 0
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous), regardless of state:
  - state=IDLE; busy=0; counter=0
  - HI=0; LO=0; temp_hi=0; temp_lo=0
  - An operation in flight is abandoned and its results are never written.
- start is defined as E_valid & (E_MDop in 1..4).
- States:
  - IDLE:
    - On start at edge k, latch the result into temp_hi/temp_lo and load the counter with MULT_CYCLES or DIV_CYCLES.
    - Go to BUSY. busy=1 during cycles k+1..k+N.
  - BUSY:
    - Decrement the counter each edge.
    - At the edge where the counter equals 1, copy temp_hi→HI and temp_lo→LO, clear busy and return to IDLE.
    - HI/LO therefore show the new values in cycle k+N+1.
- Arithmetic:
  - mult: {HI,LO} = signed(E_A) × signed(E_B), 64-bit.
  - multu: {HI,LO} = the same product, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder, which carries the sign of the dividend.
  - divu: LO = quotient; HI = remainder, both unsigned.
  - Division by zero (E_B==0, div or divu): the full busy sequence still runs, but HI/LO are left unchanged at the end.
  - Signed div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo:
  - When E_valid and in IDLE, HI (or LO) takes E_A at the next edge, with 0 latency.
  - While BUSY these ops are ignored, since md_stall prevents them from reaching E.
- mfhi/mflo:
  - E_MDout is purely combinational from the current HI/LO.
  - mthi in cycle t followed by mfhi in cycle t+1 returns the new value.
- A start while BUSY is ignored: no restart and no change to temp registers. This is an illegal sequence that md_stall prevents.
- md_stall = D_md_use & (busy | start), combinational. This covers the start cycle itself, before busy has risen.
- busy and HI/LO are registered; no output has a combinational path from E_A or E_B except through E_MDout select.

Test Plan:
- Reset sequence:
  - Stimulus: hold reset=0, then release; then mthi with E_A=0x12345678 and mtlo with 0x9ABCDEF0; then mfhi and mflo.
  - Required: E_MDout returns 0x12345678 and 0x9ABCDEF0; busy=0 throughout.
- Signed and unsigned multiply:
  - Stimulus: mult E_A=0xFFFFFFFE (-2), E_B=3 at edge k.
  - Required: busy high for cycles k+1..k+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle k+6.
  - Stimulus: multu with the same operands.
  - Required: HI=0x00000002, LO=0xFFFFFFFA.
- Signed division:
  - Stimulus: div E_A=-7 (0xFFFFFFF9), E_B=2.
  - Required: after 10 busy cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Stimulus: divu 7/2.
  - Required: LO=3, HI=1.
- Division by zero and overflow case:
  - Stimulus: HI=0xAAAA, LO=0x5555, then div by 0.
  - Required: busy high 10 cycles; HI=0xAAAA and LO=0x5555 unchanged.
  - Stimulus: div 0x80000000 / 0xFFFFFFFF.
  - Required: LO=0x80000000, HI=0.
- Stall coverage:
  - Stimulus: D_md_use=1 held during the start cycle and all busy cycles.
  - Required: md_stall=1 in every one of those cycles, falling in the cycle busy drops.
  - Stimulus: D_md_use=0.
  - Required: md_stall=0 throughout.
  - Stimulus: start with E_valid=0.
  - Required: no busy, no HI/LO change.
- Reset mid-operation:
  - Stimulus: assert reset in busy cycle 3 of a mult.
  - Required: busy=0 and HI=LO=0 immediately, without waiting for a clock edge; no later write after release.
